// File: rtl/pdma_fifo_ctrl.sv
// pdma_fifo_ctrl
// Sequences a dual-read/single-write uSRAM (write port C 128x16, read port A
// 256x8) as a word-in / byte-out FIFO that feeds the PDMA engine. Each word
// takes two byte slots, and its low byte is read out first.
//
// Ports
//   CLK, RESET     clock (rising edge); asynchronous active-high reset
//   clr            synchronous clear, same effect as RESET
//   wr_en/wr_data  word push, no backpressure (dropped when full)
//   full           fewer than 2 free byte slots
//   overflow       sticky: push attempted while full
//   rd_valid/rd_data/rd_ready  byte output stream
//   flush          pulse: request drain of residual bytes below THRESH
//   dma_req        registered PDMA request
//   byte_count     bytes in RAM plus the byte held in/for the output register
//   ram_c_*        RAM write port C
//   ram_a_*        RAM read port A (dout valid the cycle after the address edge)
module pdma_fifo_ctrl #(
  parameter int THRESH = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        full,
  output logic        overflow,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  input  logic        flush,
  output logic        dma_req,
  output logic [8:0]  byte_count,
  output logic [6:0]  ram_c_addr,
  output logic [15:0] ram_c_din,
  output logic        ram_c_wen,
  output logic        ram_c_blk,
  output logic [7:0]  ram_a_addr,
  output logic        ram_a_addr_en,
  output logic        ram_a_blk,
  input  logic [7:0]  ram_a_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, VALID = 2'd2} state_t;

  state_t     state, state_n;
  logic [8:0] count, count_n, count_ram;
  logic [6:0] wptr;
  logic [7:0] rptr;
  logic       flush_pend;
  logic       push, issue, pop, above;

  assign full       = (count > 9'd254);
  // RESET is folded in so the RAM strobes read 0 while reset is held.
  assign push       = wr_en & ~full & ~clr & ~RESET;
  // Once an address has been issued, the byte belongs to the output path
  // (FETCH or VALID). It stays in count but is no longer readable from RAM.
  assign count_ram  = count - {8'd0, (state != IDLE)};
  assign byte_count = count;
  assign above      = ({23'd0, count} >= 32'(THRESH));

  // A read address comes only from the registered count, so a word becomes
  // readable the cycle after its write edge. Write and read of one address
  // never collide.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count_ram != 9'd0) begin
          issue   = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: state_n = VALID;
      VALID: begin
        if (rd_ready) begin
          pop = 1'b1;
          if (count_ram != 9'd0) begin
            issue   = 1'b1;
            state_n = FETCH;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (clr) begin
      issue   = 1'b0;
      pop     = 1'b0;
      state_n = IDLE;
    end
  end

  // Push and pop in the same cycle fold into one update, so neither is lost.
  assign count_n = count + (push ? 9'd2 : 9'd0) - (pop ? 9'd1 : 9'd0);

  assign ram_c_wen     = push;
  assign ram_c_blk     = push;
  assign ram_c_addr    = push ? wptr : 7'd0;
  assign ram_c_din     = push ? wr_data : 16'd0;
  assign ram_a_addr_en = issue;
  assign ram_a_blk     = issue;
  assign ram_a_addr    = issue ? rptr : 8'd0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      count      <= 9'd0;
      wptr       <= 7'd0;
      rptr       <= 8'd0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'd0;
      dma_req    <= 1'b0;
    end else if (clr) begin
      // Any in-flight RAM read is discarded along with the pointers.
      state      <= IDLE;
      count      <= 9'd0;
      wptr       <= 7'd0;
      rptr       <= 8'd0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'd0;
      dma_req    <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (push)          wptr     <= wptr + 7'd1;
      if (issue)         rptr     <= rptr + 8'd1;
      if (wr_en && full) overflow <= 1'b1;
      if (state == FETCH) begin
        rd_data  <= ram_a_dout;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      dma_req <= above | (flush_pend & (count != 9'd0));
      // A flush on an empty FIFO is ignored. The pending state ends when the FIFO empties.
      if (count_n == 9'd0) flush_pend <= 1'b0;
      else if (flush && (count != 9'd0)) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pdma_fifo_ctrl.sv
// Self-checking bench for pdma_fifo_ctrl. It models the uSRAM: a registered
// read address, with data returned the following cycle. The FIFO reference
// model is a byte queue, and the expected values come from its size and
// head byte.
module tb_pdma_fifo_ctrl;
  localparam int THRESH = 64;

  logic        CLK = 1'b0, RESET = 1'b0, clr = 1'b0, wr_en = 1'b0;
  logic        rd_ready = 1'b0, flush = 1'b0;
  logic [15:0] wr_data = 16'd0;
  logic        full, overflow, rd_valid, dma_req;
  logic [7:0]  rd_data;
  logic [8:0]  byte_count;
  logic [6:0]  ram_c_addr;
  logic [15:0] ram_c_din;
  logic        ram_c_wen, ram_c_blk, ram_a_addr_en, ram_a_blk;
  logic [7:0]  ram_a_addr, ram_a_dout;

  logic [15:0] mem [128];
  logic [7:0]  a_q;

  int tests = 0, fails = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_fp, m_dreq;
  logic [6:0] m_wa;
  logic [7:0] m_ra;

  pdma_fifo_ctrl #(.THRESH(THRESH)) dut (
    .CLK(CLK), .RESET(RESET), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .overflow(overflow), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .flush(flush), .dma_req(dma_req), .byte_count(byte_count),
    .ram_c_addr(ram_c_addr), .ram_c_din(ram_c_din), .ram_c_wen(ram_c_wen),
    .ram_c_blk(ram_c_blk), .ram_a_addr(ram_a_addr), .ram_a_addr_en(ram_a_addr_en),
    .ram_a_blk(ram_a_blk), .ram_a_dout(ram_a_dout)
  );

  always #5 CLK = ~CLK;

  // uSRAM model: 16-bit write port and byte-addressed registered read port
  always @(posedge CLK) begin
    if (ram_c_wen && ram_c_blk) mem[ram_c_addr] <= ram_c_din;
    if (ram_a_blk && ram_a_addr_en) a_q <= ram_a_addr;
  end
  assign ram_a_dout = a_q[0] ? mem[a_q[7:1]][15:8] : mem[a_q[7:1]][7:0];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 0; m_fp = 0; m_dreq = 0; m_wa = 7'd0; m_ra = 8'd0;
  endtask

  // Entered just after a negedge with the inputs already driven. It checks
  // the pre-edge outputs, steps the model across the rising edge and checks
  // the registered outputs at the next negedge.
  task automatic tick();
    bit push, pop, iss;
    int c;
    #1;
    c    = q.size();
    push = wr_en && (c <= 254) && !clr;
    pop  = rd_valid && rd_ready;
    iss  = ram_a_addr_en;
    chk("ram_c_wen", 16'(ram_c_wen), 16'(push));
    if (push) begin
      chk("ram_c_addr", 16'(ram_c_addr), 16'(m_wa));
      chk("ram_c_din", ram_c_din, wr_data);
    end
    if (iss) chk("ram_a_addr", 16'(ram_a_addr), 16'(m_ra));
    if (c == 0) chk("rd_valid_empty", 16'(rd_valid), 16'd0);
    if (pop && c > 0) chk("rd_data", 16'(rd_data), 16'(q[0]));
    @(posedge CLK);
    if (clr) model_clear();
    else begin
      if (wr_en && c > 254) m_ovf = 1;
      m_dreq = (c >= THRESH) || (m_fp && c > 0);
      if (flush && c > 0) m_fp = 1;
      if (pop && c > 0) void'(q.pop_front());
      if (push) begin
        q.push_back(wr_data[7:0]);
        q.push_back(wr_data[15:8]);
        m_wa = m_wa + 7'd1;
      end
      if (iss) m_ra = m_ra + 8'd1;
      if (q.size() == 0) m_fp = 0;
    end
    @(negedge CLK);
    chk("byte_count", 16'(byte_count), 16'(q.size()));
    chk("full", 16'(full), 16'(q.size() > 254));
    chk("overflow", 16'(overflow), 16'(m_ovf));
    chk("dma_req", 16'(dma_req), 16'(m_dreq));
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < 3000 && q.size() > 0; i++) tick();
    chk(tag, 16'(q.size()), 16'd0);
    rd_ready = 1'b0;
    tick();
  endtask

  // Raises RESET mid-cycle, away from both clock edges.
  task automatic async_reset();
    #2 RESET = 1'b1;
    #1;
    chk("ar_rd_valid", 16'(rd_valid), 16'd0);
    chk("ar_rd_data", 16'(rd_data), 16'd0);
    chk("ar_byte_count", 16'(byte_count), 16'd0);
    chk("ar_dma_req", 16'(dma_req), 16'd0);
    chk("ar_overflow", 16'(overflow), 16'd0);
    chk("ar_ram_a_en", 16'(ram_a_addr_en), 16'd0);
    chk("ar_ram_a_blk", 16'(ram_a_blk), 16'd0);
    chk("ar_ram_a_addr", 16'(ram_a_addr), 16'd0);
    chk("ar_ram_c_wen", 16'(ram_c_wen), 16'd0);
    model_clear();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed;
    for (int i = 0; i < 128; i++) mem[i] = 16'd0;
    a_q = 8'd0;
    model_clear();
    #1 RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_byte_count", 16'(byte_count), 16'd0);
    chk("rst_rd_valid", 16'(rd_valid), 16'd0);
    chk("rst_rd_data", 16'(rd_data), 16'd0);
    chk("rst_dma_req", 16'(dma_req), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_ram_c_wen", 16'(ram_c_wen), 16'd0);
    chk("rst_ram_c_blk", 16'(ram_c_blk), 16'd0);
    chk("rst_ram_a_en", 16'(ram_a_addr_en), 16'd0);
    chk("rst_ram_c_addr", 16'(ram_c_addr), 16'd0);
    RESET = 1'b0;

    // Single word: 3-cycle latency with the low byte first
    wr_en = 1'b1; wr_data = 16'hA1B2; tick(); wr_en = 1'b0;
    chk("lat_write_edge", 16'(rd_valid), 16'd0);
    tick();
    chk("lat_addr_edge", 16'(rd_valid), 16'd0);
    tick();
    chk("lat_data_edge", 16'(rd_valid), 16'd1);
    chk("first_byte", 16'(rd_data), 16'h00B2);
    rd_ready = 1'b1; tick(); tick();
    chk("second_valid", 16'(rd_valid), 16'd1);
    chk("second_byte", 16'(rd_data), 16'h00A1);
    tick(); rd_ready = 1'b0; tick();
    chk("single_empty", 16'(byte_count), 16'd0);

    // Threshold: 32 words with ascending bytes and no consumer
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_data = {8'(2*i+1), 8'(2*i)}; tick();
    end
    wr_en = 1'b0; tick();
    chk("thresh_dma_req", 16'(dma_req), 16'd1);
    drain("thresh_drain");
    chk("thresh_dma_off", 16'(dma_req), 16'd0);

    // Flush with residue below the threshold
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 16'($urandom); tick();
    end
    wr_en = 1'b0; tick();
    chk("preflush_dma_req", 16'(dma_req), 16'd0);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("flush_dma_req", 16'(dma_req), 16'd1);
    drain("flush_drain");
    tick();
    chk("flush_done_dma", 16'(dma_req), 16'd0);
    flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
    chk("flush_empty_ignored", 16'(dma_req), 16'd0);

    // Fill to 256 bytes, then overflow
    for (int i = 0; i < 128; i++) begin
      wr_en = 1'b1; wr_data = 16'($urandom); tick();
    end
    wr_en = 1'b0; tick();
    chk("full_at_256", 16'(full), 16'd1);
    chk("count_256", 16'(byte_count), 16'd256);
    wr_en = 1'b1; wr_data = 16'hDEAD; tick(); wr_en = 1'b0;
    chk("overflow_set", 16'(overflow), 16'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 254; i++) tick();
    rd_ready = 1'b0; tick();
    chk("not_full_254", 16'(full), 16'd0);
    chk("overflow_sticky", 16'(overflow), 16'd1);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("clr_overflow", 16'(overflow), 16'd0);
    chk("clr_count", 16'(byte_count), 16'd0);

    // Random push/pop across both pointer wraps
    pushed = 0;
    for (int i = 0; i < 6000 && pushed < 300; i++) begin
      wr_en    = ($urandom_range(3) == 0);
      wr_data  = 16'($urandom);
      rd_ready = ($urandom_range(3) != 0);
      if (wr_en && q.size() <= 254) pushed++;
      tick();
    end
    wr_en = 1'b0;
    drain("random_drain");

    // Reset during FETCH with 10 bytes still in RAM
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 16'($urandom); tick();
    end
    wr_en = 1'b0; tick();
    chk("pre_fetch_valid", 16'(rd_valid), 16'd1);
    wr_en = 1'b1; wr_data = 16'h1234; rd_ready = 1'b1; tick();
    wr_en = 1'b0; rd_ready = 1'b0;
    chk("fetch_count", 16'(byte_count), 16'd11);
    async_reset();
    wr_en = 1'b1; wr_data = 16'h5A3C; tick(); wr_en = 1'b0;
    tick(); tick();
    chk("post_reset_byte0", 16'(rd_data), 16'h003C);
    drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pdma_fifo_ctrl.md
Name: pdma_fifo_ctrl

Overview:
- Controller that sequences the dual-read/single-write uSRAM macro (128x16 write port C, 256x8 read port A) as a word-in/byte-out FIFO feeding the PDMA engine.
- Accepts 16-bit words from the EMG sample path.
- Drives the RAM write and read ports and presents bytes on a valid/ready stream.
- Raises a DMA request when a fill threshold is reached or a flush is pending.
- RAM read port B is not driven by this block.

Parameters:
- THRESH, 64, byte count at or above which dma_req asserts. Legal range 1..256.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: same effect as RESET, one cycle.
- wr_en  in  1  push one word (no backpressure).
- wr_data  in  16  word to push.
- full  out  1  fewer than 2 free byte slots.
- overflow  out  1  sticky: push attempted while full.
- rd_valid  out  1  rd_data holds a valid byte.
- rd_data  out  8  output byte.
- rd_ready  in  1  consumer accepts byte.
- flush  in  1  pulse: request drain of the residual bytes below THRESH.
- dma_req  out  1  PDMA request.
- byte_count  out  9  bytes stored in RAM plus the byte in the output register, 0..256.
- ram_c_addr  out  7  RAM C_ADDR.
- ram_c_din  out  16  RAM C_DIN.
- ram_c_wen  out  1  RAM C_WEN, active-high.
- ram_c_blk  out  1  RAM C_BLK.
- ram_a_addr  out  8  RAM A_ADDR.
- ram_a_addr_en  out  1  RAM A_ADDR_EN.
- ram_a_blk  out  1  RAM A_BLK.
- ram_a_dout  in  8  RAM A_DOUT; valid the cycle after the address is registered.

Behaviour:
- Reset and clr values:
  - wptr = 0 (7b), rptr = 0 (8b), count = 0, state IDLE, flush_pend = 0.
  - overflow, rd_valid, rd_data, dma_req, all ram_* outputs = 0.
- Byte order: word w occupies read addresses 2w (wr_data[7:0]) and 2w+1 (wr_data[15:8]), so the low byte is output first.
- Write side:
  - full = (count > 254).
  - wr_en & ~full: ram_c_wen = ram_c_blk = 1 combinationally, ram_c_addr = wptr, ram_c_din = wr_data. Then wptr += 1 (wraps 127 -> 0) and count += 2.
  - wr_en & full: no RAM write, word is dropped, overflow <= 1. overflow clears only on RESET/clr.
- Read FSM:
  - IDLE: if count_ram > 0 (count minus the output-register byte), drive ram_a_addr = rptr with ram_a_blk = ram_a_addr_en = 1, rptr += 1 (wraps 255 -> 0), go to FETCH.
  - FETCH: rd_data <= ram_a_dout, rd_valid <= 1, go to VALID.
  - VALID: on rd_ready, count -= 1 and rd_valid <= 0.
    - If count_ram > 0 in the same cycle, issue the next address and go to FETCH.
    - Otherwise go to IDLE.
  - Throughput is 1 byte per 2 cycles. Latency from a write into an empty FIFO to rd_valid = 3 cycles: write edge, address edge, data edge.
- Read-after-write: a read address is issued no earlier than the cycle after the write edge, so there is no same-cycle collision.
- Simultaneous push and pop: count += 2 - 1 in one cycle, never a lost update.
- dma_req (registered) = (count >= THRESH) | (flush_pend & count > 0).
- flush_pend:
  - Set by flush, which is ignored when count = 0.
  - Cleared when count reaches 0.
  - A flush during an active flush is a no-op.
- clr/RESET mid-transfer: rd_valid drops immediately (RESET) or next edge (clr); the in-flight RAM read is discarded.

Test Plan:
- Reset, then push 0xA1B2 -> ram_c_wen for one cycle at addr 0; rd_valid 3 cycles later with rd_data 0xB2, then 0xA1; byte_count goes 2 -> 0.
- THRESH=64, push 32 words with rd_ready=0 -> dma_req rises the cycle after count reaches 64. Drain all -> dma_req falls when count < 64, bytes appear in ascending order.
- Push 3 words, pulse flush -> dma_req = 1 until 6 bytes are drained, then 0 with flush_pend cleared.
- Push 128 words -> full = 1 at count 256; a 129th push -> no ram_c_wen, overflow = 1; pop 2 bytes -> full = 0; overflow stays 1 until clr.
- Continuous push/pop across the wrap (wptr 127->0, rptr 255->0) -> data integrity over 300 words, count consistent on cycles with a simultaneous push and pop.
- Assert RESET while state = FETCH with 10 bytes stored -> all outputs 0, byte_count 0; next push is read back from address 0.
